mem_bus_arbiter: RTL and testbench

//  Shares one memory port between the core's instruction fetch bus (ibus) and data bus (dbus).

---
 rtl/mem_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch (ibus) and data (dbus).
// Data side wins ties; a streak counter hands the port to a waiting fetch after D_STREAK_MAX data grants.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int D_STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [31:0]         i_data,

    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [2:0]          d_size,
    input  logic [DATA_W/8-1:0] d_strobe,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [2:0]          m_size,
    output logic [DATA_W/8-1:0] m_strobe,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata,

    output logic                owner_d,
    output logic [1:0]          dbg_state_o,
    output logic [3:0]          dbg_streak_o
);

    localparam int             SW         = DATA_W / 8;
    localparam logic [3:0]     STREAK_MAX = 4'(D_STREAK_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                own_q, own_d;
    logic [3:0]          streak_q, streak_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [SW-1:0]       strobe_q, strobe_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                streak_at_max;
    logic                take_d;
    logic                take_i;
    logic                addr_hit;
    logic                data_hit;

    // Arbitration is only evaluated in IDLE; the streak gate lets a waiting fetch through.
    always_comb begin
        streak_at_max = (streak_q == STREAK_MAX);
        take_d        = 1'b0;
        take_i        = 1'b0;
        if (state_q == S_IDLE) begin
            take_d = d_valid & ~(i_valid & streak_at_max);
            take_i = i_valid & ~take_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (take_d || take_i) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (m_addr_ok) begin
                    state_d = m_data_ok ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. Handshakes are suppressed while reset is high so nothing leaks out mid-reset.
    always_comb begin
        m_valid  = 1'b0;
        addr_hit = 1'b0;
        data_hit = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_REQ: begin
                    m_valid  = 1'b1;
                    addr_hit = m_addr_ok;
                    data_hit = m_addr_ok & m_data_ok;
                end
                S_WAIT: begin
                    data_hit = m_data_ok;
                end
                default: ;
            endcase
        end
        i_addr_ok = addr_hit & ~own_q;
        d_addr_ok = addr_hit &  own_q;
        i_data_ok = data_hit & ~own_q;
        d_data_ok = data_hit &  own_q;
    end

    // Request latch, owner and streak change only on a grant.
    always_comb begin
        own_d    = own_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        if (take_d) begin
            own_d    = 1'b1;
            addr_d   = d_addr;
            size_d   = d_size;
            strobe_d = d_strobe;
            wdata_d  = d_wdata;
            if (!i_valid) begin
                streak_d = 4'd0;
            end else if (!streak_at_max) begin
                streak_d = streak_q + 4'd1;
            end
        end else if (take_i) begin
            own_d    = 1'b0;
            addr_d   = i_addr;
            size_d   = 3'd2;
            strobe_d = '0;
            wdata_d  = '0;
            streak_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            own_q    <= 1'b0;
            streak_q <= 4'd0;
            addr_q   <= '0;
            size_q   <= 3'd0;
            strobe_q <= '0;
            wdata_q  <= '0;
        end else begin
            own_q    <= own_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
        end
    end

    assign m_addr   = addr_q;
    assign m_size   = size_q;
    assign m_strobe = strobe_q;
    assign m_wdata  = wdata_q;

    // Fetch lane follows the latched address, not the live i_addr.
    assign i_data   = addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
    assign d_rdata  = m_rdata;

    assign owner_d      = own_q;
    assign dbg_state_o  = state_q;
    assign dbg_streak_o = streak_q;

    a_streak_bound: assert property (@(posedge clk) disable iff (reset)
        streak_q <= STREAK_MAX);

    a_latch_stable: assert property (@(posedge clk) disable iff (reset)
        (state_q != S_IDLE) |=> ($stable(addr_q) && $stable(strobe_q) && $stable(own_q)));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: scenario tasks drive both requesters and a scripted memory;
// returned data is checked against an expected queue filled when each request is issued.
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int SW = DATA_W / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_valid = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic i_addr_ok, i_data_ok;
  logic [31:0] i_data;
  logic d_valid = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [2:0] d_size = '0;
  logic [SW-1:0] d_strobe = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic d_addr_ok, d_data_ok;
  logic [DATA_W-1:0] d_rdata;
  logic m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0] m_size;
  logic [SW-1:0] m_strobe;
  logic [DATA_W-1:0] m_wdata;
  logic m_addr_ok = 1'b0;
  logic m_data_ok = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic owner_d;
  logic [1:0] dbg_state_o;
  logic [3:0] dbg_streak_o;

  int n_tests = 0;
  int n_fail = 0;

  // {owner (1=dbus), returned data}; ibus entries carry the selected 32-bit lane zero-extended.
  logic [64:0] exp_q[$];
  logic [64:0] mon_got, mon_exp;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .D_STREAK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .owner_d(owner_d), .dbg_state_o(dbg_state_o), .dbg_streak_o(dbg_streak_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // scoreboard: every data_ok pops one expected entry
  always @(negedge clk) begin
    if (i_data_ok && d_data_ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_both_data_ok i=%b d=%b want one", i_data_ok, d_data_ok);
    end else if (i_data_ok || d_data_ok) begin
      mon_got = i_data_ok ? {1'b0, 32'h0, i_data} : {1'b1, d_rdata};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected got=%h want=nothing", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_data got=%h want=%h", mon_got, mon_exp);
        end
      end
    end
  end

  function automatic logic [64:0] ilane(input logic [63:0] a, input logic [63:0] rd);
    return {1'b0, 32'h0, (a[2] ? rd[63:32] : rd[31:0])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory driver: waits for a request, accepts the address after a_wait cycles,
  // completes d_lat cycles later (0 = same cycle as the address)
  task automatic mem_serve(input logic exp_own, input logic [63:0] exp_addr,
                           input int a_wait, input int d_lat, input logic [63:0] rd);
    int n;
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    n_tests++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_req_timeout m_valid=%b want=1", m_valid);
      return;
    end
    n_tests++;
    if (m_addr !== exp_addr) begin n_fail++; $display("FAIL mem_addr got=%h want=%h", m_addr, exp_addr); end
    n_tests++;
    if (owner_d !== exp_own) begin n_fail++; $display("FAIL mem_owner got=%b want=%b", owner_d, exp_own); end
    repeat (a_wait) tick();
    m_addr_ok = 1'b1;
    if (d_lat == 0) begin
      m_data_ok = 1'b1;
      m_rdata = rd;
    end
    #1;
    n_tests++;
    if ({i_addr_ok, d_addr_ok} !== (exp_own ? 2'b01 : 2'b10)) begin
      n_fail++;
      $display("FAIL addr_ok_route got=%b%b want_owner=%b", i_addr_ok, d_addr_ok, exp_own);
    end
    tick();
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    if (d_lat > 0) begin
      #1;
      n_tests++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL wait_m_valid got=%b want=0", m_valid); end
      repeat (d_lat - 1) tick();
      m_data_ok = 1'b1;
      m_rdata = rd;
      tick();
      m_data_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    #1;
    n_tests++;
    if ({m_valid, owner_d, dbg_state_o, dbg_streak_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b%b %h %h want=0", m_valid, owner_d, dbg_state_o, dbg_streak_o);
    end
    n_tests++;
    if ({m_addr, m_size, m_strobe, m_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields addr=%h size=%h strobe=%h want=0", m_addr, m_size, m_strobe);
    end
    n_tests++;
    if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_oks got=%b%b%b%b want=0000", i_addr_ok, d_addr_ok, i_data_ok, d_data_ok);
    end
    reset = 1'b0;
    tick();
    #1;
    n_tests++;
    if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL reset_idle got=%0d want=0", dbg_state_o); end
  endtask

  task automatic test_ifetch();
    logic [63:0] rd;
    rd = 64'hAAAA_BBBB_CCCC_DDDD;
    i_addr = 64'h8000_0004;
    i_valid = 1'b1;
    exp_q.push_back({1'b0, 32'h0, 32'hAAAA_BBBB});
    #1;
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ifetch_grant_cycle m_valid=%b want=0", m_valid); end
    tick();
    #1;
    n_tests++;
    if ({m_valid, m_size, m_strobe, m_wdata} !== {1'b1, 3'd2, 8'h00, 64'h0}) begin
      n_fail++;
      $display("FAIL ifetch_req valid=%b size=%0d strobe=%h wdata=%h want 1/2/0/0", m_valid, m_size, m_strobe, m_wdata);
    end
    mem_serve(1'b0, 64'h8000_0004, 0, 2, rd);
    i_valid = 1'b0;
  endtask

  task automatic test_d_over_i();
    logic [63:0] rd_d, rd_i;
    rd_d = 64'h0123_4567_89AB_CDEF;
    rd_i = 64'hFEED_FACE_DEAD_BEEF;
    d_addr = 64'h0000_1000;
    d_size = 3'd3;
    d_strobe = 8'hFF;
    d_wdata = 64'h1122_3344_5566_7788;
    i_addr = 64'h0000_2000;
    d_valid = 1'b1;
    i_valid = 1'b1;
    exp_q.push_back({1'b1, rd_d});
    exp_q.push_back(ilane(64'h0000_2000, rd_i));
    tick();
    #1;
    n_tests++;
    if ({owner_d, m_strobe, m_size, m_wdata} !== {1'b1, 8'hFF, 3'd3, 64'h1122_3344_5566_7788}) begin
      n_fail++;
      $display("FAIL d_first owner=%b strobe=%h size=%0d wdata=%h", owner_d, m_strobe, m_size, m_wdata);
    end
    n_tests++;
    if (dbg_streak_o !== 4'd1) begin n_fail++; $display("FAIL d_first_streak got=%0d want=1", dbg_streak_o); end
    mem_serve(1'b1, 64'h0000_1000, 1, 1, rd_d);
    d_valid = 1'b0;
    #1;
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rearb_idle m_valid=%b want=0", m_valid); end
    tick();
    #1;
    n_tests++;
    if ({owner_d, m_size, m_strobe, m_wdata, dbg_streak_o} !== {1'b0, 3'd2, 8'h00, 64'h0, 4'd0}) begin
      n_fail++;
      $display("FAIL i_second owner=%b size=%0d strobe=%h streak=%0d", owner_d, m_size, m_strobe, dbg_streak_o);
    end
    mem_serve(1'b0, 64'h0000_2000, 0, 0, rd_i);
    i_valid = 1'b0;
  endtask

  task automatic test_streak();
    logic [63:0] rd[5];
    int n;
    for (int k = 0; k < 5; k++) rd[k] = {$urandom, $urandom};
    d_addr = 64'h0000_4008;
    d_size = 3'd3;
    d_strobe = 8'h00;
    d_wdata = 64'h0;
    i_addr = 64'h0000_3004;
    d_valid = 1'b1;
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, rd[k]});
    exp_q.push_back(ilane(64'h0000_3004, rd[4]));
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!m_valid && n < 20) begin
        tick();
        n++;
      end
      #1;
      n_tests++;
      if ({owner_d, dbg_streak_o} !== ((k < 4) ? {1'b1, 4'(k + 1)} : {1'b0, 4'd0})) begin
        n_fail++;
        $display("FAIL streak_k%0d owner=%b streak=%0d", k, owner_d, dbg_streak_o);
      end
      mem_serve((k < 4), (k < 4) ? 64'h0000_4008 : 64'h0000_3004, 0, 0, rd[k]);
    end
    d_valid = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [63:0] rd;
    rd = {$urandom, $urandom};
    d_addr = 64'h0000_0000_5555_0010;
    d_size = 3'd2;
    d_strobe = 8'h00;
    d_valid = 1'b1;
    exp_q.push_back({1'b1, rd});
    mem_serve(1'b1, 64'h0000_0000_5555_0010, 0, 0, rd);
    d_valid = 1'b0;
    #1;
    n_tests++;
    if ({dbg_state_o, m_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL same_cycle_idle state=%0d m_valid=%b want 0/0", dbg_state_o, m_valid);
    end
  endtask

  task automatic test_ignored();
    logic [63:0] rd;
    rd = {$urandom, $urandom};
    m_addr_ok = 1'b1;
    m_data_ok = 1'b1;
    m_rdata = rd;
    #1;
    n_tests++;
    if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_ignore got=%b%b%b%b want=0000", i_addr_ok, d_addr_ok, i_data_ok, d_data_ok);
    end
    tick();
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    d_addr = 64'h0000_7770;
    d_strobe = 8'h00;
    d_valid = 1'b1;
    exp_q.push_back({1'b1, rd});
    tick();
    m_data_ok = 1'b1;
    #1;
    n_tests++;
    if (d_data_ok !== 1'b0) begin n_fail++; $display("FAIL req_data_only got=%b want=0", d_data_ok); end
    tick();
    m_data_ok = 1'b0;
    #1;
    n_tests++;
    if (dbg_state_o !== 2'd1) begin n_fail++; $display("FAIL req_hold got=%0d want=1", dbg_state_o); end
    mem_serve(1'b1, 64'h0000_7770, 0, 1, rd);
    d_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    d_addr = 64'h0000_9000;
    i_addr = 64'h0000_A000;
    d_valid = 1'b1;
    i_valid = 1'b1;
    tick();
    #1;
    n_tests++;
    if ({owner_d, dbg_streak_o} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL rmid_req owner=%b streak=%0d want 1/1", owner_d, dbg_streak_o);
    end
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0;
    #1;
    n_tests++;
    if (dbg_state_o !== 2'd2) begin n_fail++; $display("FAIL rmid_wait got=%0d want=2", dbg_state_o); end
    reset = 1'b1;
    d_valid = 1'b0;
    i_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({dbg_state_o, m_valid, owner_d, dbg_streak_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_idle state=%0d m_valid=%b owner=%b streak=%0d want 0", dbg_state_o, m_valid, owner_d, dbg_streak_o);
    end
    m_data_ok = 1'b1;
    m_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    #1;
    n_tests++;
    if ({i_data_ok, d_data_ok} !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_late_data got=%b%b want=00", i_data_ok, d_data_ok);
    end
    tick();
    m_data_ok = 1'b0;
  endtask

  task automatic test_latch_hold();
    logic [63:0] rd;
    rd = {$urandom, $urandom};
    d_addr = 64'h0000_1230;
    d_size = 3'd2;
    d_strobe = 8'h0F;
    d_wdata = 64'hCAFE_0000_BABE_1111;
    d_valid = 1'b1;
    exp_q.push_back({1'b1, rd});
    tick();
    d_addr = 64'h0000_9990;
    d_size = 3'd0;
    d_strobe = 8'hF0;
    d_wdata = 64'h0;
    #1;
    n_tests++;
    if ({m_addr, m_size, m_strobe, m_wdata} !== {64'h0000_1230, 3'd2, 8'h0F, 64'hCAFE_0000_BABE_1111}) begin
      n_fail++;
      $display("FAIL latch_hold addr=%h size=%0d strobe=%h wdata=%h", m_addr, m_size, m_strobe, m_wdata);
    end
    tick();
    #1;
    n_tests++;
    if (m_addr !== 64'h0000_1230) begin n_fail++; $display("FAIL latch_hold2 got=%h want=1230", m_addr); end
    mem_serve(1'b1, 64'h0000_1230, 0, 3, rd);
    d_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd, a;
    for (int k = 0; k < 8; k++) begin
      rd = {$urandom, $urandom};
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        a = a & 64'hFFFF_FFFF_FFFF_FFFC;
        i_addr = a;
        i_valid = 1'b1;
        exp_q.push_back(ilane(a, rd));
        mem_serve(1'b0, a, $urandom_range(0, 2), $urandom_range(0, 2), rd);
        i_valid = 1'b0;
      end else begin
        d_addr = a;
        d_size = 3'($urandom_range(0, 3));
        d_strobe = 8'($urandom_range(0, 255));
        d_wdata = {$urandom, $urandom};
        d_valid = 1'b1;
        exp_q.push_back({1'b1, rd});
        mem_serve(1'b1, a, $urandom_range(0, 2), $urandom_range(0, 2), rd);
        d_valid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_d_over_i();
    test_streak();
    test_same_cycle();
    test_ignored();
    test_reset_mid();
    test_latch_hold();
    test_back_to_back();
    repeat (3) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
